vehicle_sensor_emulator: RTL and testbench

- Generates the two-sensor S1/S2 waveforms a physical vehicle produces when crossing the gate.
- Host logic queues "enter" or "exit" commands through a valid/ready port. The block replays each command as the four-phase sensor sequence that the vehicle detection logic decodes.
- Drives the counter path on-board for demo and self-test, without real sensors.
- Outputs are registered and connect in place of the S1/S2 pins, upstream of the synchronizers.

---
 rtl/veh_pkg.sv | 22 ++
 rtl/emu_cmd_fifo.sv | 53 +++++
 rtl/vehicle_sensor_emulator.sv | 177 +++++++++++++++++
 tb/tb_vehicle_sensor_emulator.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/veh_pkg.sv
// rtl/veh_pkg.sv - shared types for the vehicle sensor emulator
// Purpose: FSM state encoding, vehicle direction, queued command record and
//          a small constant helper used for sizing the phase timer.
// Optional feature macro: VEH_EMU_BACKOUT_EN (adds the backout flag to a command).
package veh_pkg;

  typedef enum logic [2:0] {IDLE, LEAD, BOTH, TRAIL, GAP} emu_state_t;

  typedef enum logic {DIR_ENTER = 1'b0, DIR_EXIT = 1'b1} veh_dir_t;

  typedef struct packed {
`ifdef VEH_EMU_BACKOUT_EN
    logic     backout;
`endif
    veh_dir_t dir;
  } veh_cmd_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/emu_cmd_fifo.sv
// rtl/emu_cmd_fifo.sv - synchronous command queue for the sensor emulator
// Purpose: DEPTH-entry FIFO of veh_cmd_t with wrap-bit pointers.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (empties the queue)
//   push, push_data     write request and data (ignored while full)
//   full                queue full, decoded from registered pointers only
//   pop, pop_data       read request (ignored while empty) and head entry
//   empty               queue empty, decoded from registered pointers only
module emu_cmd_fifo
  import veh_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  veh_cmd_t push_data,
  output logic     full,
  input  logic     pop,
  output veh_cmd_t pop_data,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  veh_cmd_t        mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic            do_push;
  logic            do_pop;

  // Extra MSB distinguishes full (wrap bits differ) from empty (all equal).
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/vehicle_sensor_emulator.sv
// rtl/vehicle_sensor_emulator.sv - replays queued enter/exit commands as S1/S2 waveforms
// Purpose: pops direction commands and drives the four-phase two-sensor
//          pattern a real vehicle produces, for demo and self-test.
// Optional feature macro: VEH_EMU_BACKOUT_EN (cmd_backout input; vehicle
//          backs out after BOTH and never reaches TRAIL).
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid, cmd_dir    command handshake input, 0 = enter, 1 = exit
//   cmd_backout           (macro only) command is a back-out vehicle
//   cmd_ready             queue can accept a command
//   S1, S2                emulated outer / inner sensor, registered
//   busy                  sequence running or commands queued, registered
//   done, done_dir        one-cycle completion pulse and its direction
//   done_backout          completed vehicle backed out (always 0 without macro)
module vehicle_sensor_emulator
  import veh_pkg::*;
#(
  parameter int PHASE_CYCLES = 16,
  parameter int GAP_CYCLES   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_dir,
`ifdef VEH_EMU_BACKOUT_EN
  input  logic cmd_backout,
`endif
  output logic cmd_ready,
  output logic S1,
  output logic S2,
  output logic busy,
  output logic done,
  output logic done_dir,
  output logic done_backout
);

  localparam int TW = $clog2(max_int(PHASE_CYCLES, GAP_CYCLES) + 1);
  localparam logic [TW-1:0] PHASE_LOAD = TW'(PHASE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LOAD   = TW'(GAP_CYCLES - 1);

  emu_state_t     state;
  logic [TW-1:0]  timer;
  veh_cmd_t       cur;
  logic           second_lead;   // in the LEAD that follows BOTH of a back-out
  veh_cmd_t       in_cmd;
  veh_cmd_t       head_cmd;
  logic           fifo_full;
  logic           fifo_empty;
  logic           pop;
  logic           is_backout;
  logic           lead_on;
  logic           trail_on;
  logic           s1_next;
  logic           s2_next;
  logic           done_next;

  always_comb begin
    in_cmd     = '0;
    in_cmd.dir = veh_dir_t'(cmd_dir);
`ifdef VEH_EMU_BACKOUT_EN
    in_cmd.backout = cmd_backout;
`endif
  end

`ifdef VEH_EMU_BACKOUT_EN
  assign is_backout = cur.backout;
`else
  assign is_backout = 1'b0;
`endif

  assign cmd_ready = !fifo_full;
  assign pop       = (state == IDLE) && !fifo_empty;

  emu_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (cmd_valid),
    .push_data(in_cmd),
    .full     (fifo_full),
    .pop      (pop),
    .pop_data (head_cmd),
    .empty    (fifo_empty)
  );

  // Sensor levels implied by the current state; registered one cycle later so
  // every output is a clean flop and all phases shift uniformly.
  always_comb begin
    lead_on  = 1'b0;
    trail_on = 1'b0;
    case (state)
      LEAD:    lead_on  = 1'b1;
      BOTH:    begin lead_on = 1'b1; trail_on = 1'b1; end
      TRAIL:   trail_on = 1'b1;
      default: ;
    endcase
  end

  assign s1_next   = (cur.dir == DIR_EXIT) ? trail_on : lead_on;
  assign s2_next   = (cur.dir == DIR_EXIT) ? lead_on  : trail_on;
  assign done_next = (state == GAP) && (timer == GAP_LOAD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      cur          <= '0;
      second_lead  <= 1'b0;
      S1           <= 1'b0;
      S2           <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_dir     <= 1'b0;
      done_backout <= 1'b0;
    end else begin
      S1           <= s1_next;
      S2           <= s2_next;
      busy         <= (state != IDLE) || !fifo_empty;
      done         <= done_next;
      done_dir     <= done_next ? 1'(cur.dir) : 1'b0;
      done_backout <= done_next && is_backout;

      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            cur         <= head_cmd;
            timer       <= PHASE_LOAD;
            second_lead <= 1'b0;
            state       <= LEAD;
          end
        end
        LEAD: begin
          if (timer == '0) begin
            if (second_lead) begin
              timer <= GAP_LOAD;
              state <= GAP;
            end else begin
              timer <= PHASE_LOAD;
              state <= BOTH;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        BOTH: begin
          if (timer == '0) begin
            timer <= PHASE_LOAD;
            if (is_backout) begin
              second_lead <= 1'b1;
              state       <= LEAD;
            end else begin
              state <= TRAIL;
            end
          end else begin
            timer <= timer - TW'(1);
          end
        end
        TRAIL: begin
          if (timer == '0) begin
            timer <= GAP_LOAD;
            state <= GAP;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        GAP: begin
          if (timer == '0) state <= IDLE;
          else             timer <= timer - TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vehicle_sensor_emulator.sv
// tb/tb_vehicle_sensor_emulator.sv - directed self-checking bench for vehicle_sensor_emulator
module tb_vehicle_sensor_emulator;

  logic clk;
  logic rst_n;
  logic cmd_valid;
  logic cmd_dir;
  logic cmd_backout;
  logic cmd_ready;
  logic S1;
  logic S2;
  logic busy;
  logic done;
  logic done_dir;
  logic done_backout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  vehicle_sensor_emulator #(
    .PHASE_CYCLES(4),
    .GAP_CYCLES  (3),
    .FIFO_DEPTH  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_dir     (cmd_dir),
`ifdef VEH_EMU_BACKOUT_EN
    .cmd_backout (cmd_backout),
`endif
    .cmd_ready   (cmd_ready),
    .S1          (S1),
    .S2          (S2),
    .busy        (busy),
    .done        (done),
    .done_dir    (done_dir),
    .done_backout(done_backout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Independent sensor decoder: counts +1 for 10,11,01,00 and -1 for 01,11,10,00.
  logic [1:0] prev_ss   = 2'b00;
  logic [7:0] hist      = 8'h00;
  int         veh_count = 0;
  always @(negedge clk) begin
    if ({S1, S2} != prev_ss) begin
      hist    = {hist[5:0], S1, S2};
      prev_ss = {S1, S2};
      if ({S1, S2} == 2'b00) begin
        if (hist == 8'b10_11_01_00)      veh_count++;
        else if (hist == 8'b01_11_10_00) veh_count--;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_cmd(input logic dir, input logic bo);
    int guard;
    guard       = 0;
    cmd_valid   = 1'b1;
    cmd_dir     = dir;
    cmd_backout = bo;
    while (!cmd_ready && guard < 200) begin
      tick();
      guard++;
    end
    total_cnt++;
    if (guard >= 200) $display("FAIL push_timeout cmd_ready stuck at %0b, required 1", cmd_ready);
    else pass_cnt++;
    tick();
    cmd_valid   = 1'b0;
    cmd_backout = 1'b0;
  endtask

  task automatic test_reset();
    total_cnt++; if ({S1, S2} !== 2'b00) $display("FAIL reset_sensors got %b required 00", {S1, S2}); else pass_cnt++;
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL reset_cmd_ready got %b required 1", cmd_ready); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b required 0", busy); else pass_cnt++;
    total_cnt++; if ({done, done_dir, done_backout} !== 3'b000) $display("FAIL reset_done got %b required 000", {done, done_dir, done_backout}); else pass_cnt++;
  endtask

  // Accept edge is k=0; lead rises k=2, trail k=6, lead falls k=10,
  // trail falls k=14 with done, busy low from k=17.
  task automatic test_single(input logic dir);
    logic lead_e, trail_e, s1_e, s2_e, busy_e, done_e, ps1, ps2;
    push_cmd(dir, 1'b0);
    ps1 = S1;
    ps2 = S2;
    for (int k = 1; k <= 18; k++) begin
      tick();
      lead_e  = (k >= 2) && (k < 10);
      trail_e = (k >= 6) && (k < 14);
      s1_e    = dir ? trail_e : lead_e;
      s2_e    = dir ? lead_e : trail_e;
      busy_e  = (k < 17);
      done_e  = (k == 14);
      total_cnt++; if ({S1, S2} !== {s1_e, s2_e}) $display("FAIL single%0b_sensors k=%0d got %b required %b", dir, k, {S1, S2}, {s1_e, s2_e}); else pass_cnt++;
      total_cnt++; if ({busy, done} !== {busy_e, done_e}) $display("FAIL single%0b_busy_done k=%0d got %b required %b", dir, k, {busy, done}, {busy_e, done_e}); else pass_cnt++;
      total_cnt++; if ((S1 != ps1) && (S2 != ps2)) $display("FAIL single%0b_same_cycle_toggle k=%0d got both required one", dir, k); else pass_cnt++;
      if (k == 14) begin
        total_cnt++; if ({done_dir, done_backout} !== {dir, 1'b0}) $display("FAIL single%0b_done_dir got %b required %b", dir, {done_dir, done_backout}, {dir, 1'b0}); else pass_cnt++;
      end
      ps1 = S1;
      ps2 = S2;
    end
  endtask

  task automatic test_burst();
    logic dirs [6];
    int   acc_req [6];
    int   acc_k [6];
    int   done_k [6];
    logic done_d [6];
    int   n, nd, low;
    logic rdy;
    dirs    = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    acc_req = '{0, 1, 2, 3, 4, 18};
    n = 0; nd = 0; low = 0;
    cmd_valid = 1'b1;
    cmd_dir   = dirs[0];
    for (int k = 0; k < 110; k++) begin
      rdy = cmd_ready;
      tick();
      if (cmd_valid && rdy) begin
        acc_k[n] = k;
        n++;
        if (n == 6) cmd_valid = 1'b0;
        else        cmd_dir   = dirs[n];
      end
      if (k == 5 || k == 16) begin
        total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL burst_full_ready k=%0d got %b required 0", k, cmd_ready); else pass_cnt++;
      end
      if (done) begin
        if (nd < 6) begin done_k[nd] = k; done_d[nd] = done_dir; end
        nd++;
      end
      if (k >= 14 && k <= 17 && !S1 && !S2) low++;
      if (k == 18) begin
        total_cnt++; if ({S1, S2} !== 2'b01) $display("FAIL burst_second_lead got %b required 01", {S1, S2}); else pass_cnt++;
      end
    end
    total_cnt++; if (n !== 6) $display("FAIL burst_accept_count got %0d required 6", n); else pass_cnt++;
    total_cnt++; if (nd !== 6) $display("FAIL burst_done_count got %0d required 6", nd); else pass_cnt++;
    total_cnt++; if (low !== 4) $display("FAIL burst_gap_low got %0d required 4", low); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      if (i < n) begin
        total_cnt++; if (acc_k[i] !== acc_req[i]) $display("FAIL burst_accept_edge%0d got %0d required %0d", i, acc_k[i], acc_req[i]); else pass_cnt++;
      end
      if (i < nd) begin
        total_cnt++; if (done_k[i] !== 14 + 16 * i) $display("FAIL burst_done_edge%0d got %0d required %0d", i, done_k[i], 14 + 16 * i); else pass_cnt++;
        total_cnt++; if (done_d[i] !== dirs[i]) $display("FAIL burst_done_dir%0d got %b required %b", i, done_d[i], dirs[i]); else pass_cnt++;
      end
    end
    total_cnt++; if (busy !== 1'b0) $display("FAIL burst_busy_end got %b required 0", busy); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic any_act;
    cmd_valid = 1'b1;
    cmd_dir   = 1'b0;
    repeat (3) tick();          // accepts at k=0,1,2; first pops at k=1
    cmd_valid = 1'b0;
    repeat (5) tick();          // k=7: inside BOTH
    total_cnt++; if ({S1, S2} !== 2'b11) $display("FAIL rstmid_both got %b required 11", {S1, S2}); else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++; if ({S1, S2} !== 2'b00) $display("FAIL rstmid_async_drop got %b required 00", {S1, S2}); else pass_cnt++;
    total_cnt++; if ({cmd_ready, busy} !== 2'b10) $display("FAIL rstmid_ready_busy got %b required 10", {cmd_ready, busy}); else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    any_act = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      any_act = any_act | S1 | S2 | done | busy;
    end
    total_cnt++; if (any_act !== 1'b0) $display("FAIL rstmid_no_replay got %b required 0", any_act); else pass_cnt++;
  endtask

  task automatic test_closed_loop();
    logic seq [9];
    int   base, guard;
    seq  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    base = veh_count;
    for (int i = 0; i < 9; i++) push_cmd(seq[i], 1'b0);
    guard = 0;
    while (busy && guard < 400) begin tick(); guard++; end
    total_cnt++; if (guard >= 400) $display("FAIL loop_idle_timeout busy got %b required 0", busy); else pass_cnt++;
    repeat (2) tick();
    total_cnt++; if (veh_count - base !== 5) $display("FAIL loop_count got %0d required 5", veh_count - base); else pass_cnt++;
  endtask

`ifdef VEH_EMU_BACKOUT_EN
  task automatic test_backout();
    int   base, n1, n2, ndone;
    logic s2_alone, bo_seen;
    base = veh_count; n1 = 0; n2 = 0; ndone = 0; s2_alone = 1'b0; bo_seen = 1'b0;
    push_cmd(1'b0, 1'b1);
    for (int k = 1; k <= 30; k++) begin
      tick();
      n1 += int'(S1);
      n2 += int'(S2);
      if (S2 && !S1) s2_alone = 1'b1;
      if (done) begin ndone++; bo_seen = done_backout && !done_dir; end
    end
    total_cnt++; if (n1 !== 12) $display("FAIL backout_s1_cycles got %0d required 12", n1); else pass_cnt++;
    total_cnt++; if (n2 !== 4) $display("FAIL backout_s2_cycles got %0d required 4", n2); else pass_cnt++;
    total_cnt++; if (s2_alone !== 1'b0) $display("FAIL backout_s2_alone got %b required 0", s2_alone); else pass_cnt++;
    total_cnt++; if ({ndone == 1, bo_seen} !== 2'b11) $display("FAIL backout_done got %0d/%b required 1/1", ndone, bo_seen); else pass_cnt++;
    total_cnt++; if (veh_count - base !== 0) $display("FAIL backout_count got %0d required 0", veh_count - base); else pass_cnt++;
  endtask
`endif

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time exceeded, required finish");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    cmd_valid   = 1'b0;
    cmd_dir     = 1'b0;
    cmd_backout = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    repeat (2) tick();
    test_single(1'b0);
    repeat (2) tick();
    test_single(1'b1);
    repeat (2) tick();
    test_burst();
    test_reset_mid();
    test_closed_loop();
`ifdef VEH_EMU_BACKOUT_EN
    test_backout();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
